// File: rtl/gate_eval_pkg.sv
// Shared op codes, sequencer states and sweep constants for the gate evaluation sequencer.
package gate_eval_pkg;

  localparam logic [2:0] OP_NAND       = 3'd0;
  localparam logic [2:0] OP_NOR        = 3'd1;
  localparam logic [2:0] OP_AND        = 3'd2;
  localparam logic [2:0] OP_OR         = 3'd3;
  localparam logic [2:0] OP_XOR        = 3'd4;
  localparam logic [2:0] OP_XNOR       = 3'd5;
  localparam logic [2:0] OP_LAST_LEGAL = 3'd5;

  localparam int unsigned NUM_VECTORS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/gate_nand_unit.sv
// Gate-level two-input function unit: every function is built from 2-input nand primitives,
// then selected by op. Illegal op codes yield 0.
module gate_nand_unit
  import gate_eval_pkg::*;
(
  output logic       s,
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op
);

  logic n_ab, n_a, n_b, f_and, f_or, f_nor, n_ax, n_bx, f_xor, f_xnor;

  nand u_nab  (n_ab,   a,     b);
  nand u_and  (f_and,  n_ab,  n_ab);
  nand u_na   (n_a,    a,     a);
  nand u_nb   (n_b,    b,     b);
  nand u_or   (f_or,   n_a,   n_b);
  nand u_nor  (f_nor,  f_or,  f_or);
  nand u_nax  (n_ax,   a,     n_ab);
  nand u_nbx  (n_bx,   b,     n_ab);
  nand u_xor  (f_xor,  n_ax,  n_bx);
  nand u_xnor (f_xnor, f_xor, f_xor);

  always_comb begin
    s = 1'b0;
    case (op)
      OP_NAND: s = n_ab;
      OP_NOR:  s = f_nor;
      OP_AND:  s = f_and;
      OP_OR:   s = f_or;
      OP_XOR:  s = f_xor;
      OP_XNOR: s = f_xnor;
      default: s = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_eval_sequencer.sv
// Sweeps all four {x,y} vectors through the nand-only unit and an expression model,
// counting mismatches and reporting the first failing vector over start/busy/done.
module gate_eval_sequencer
  import gate_eval_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [3:0] fault_mask,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail,
  output logic       first_fail_valid,
  output logic       illegal_op,
  output logic       x,
  output logic       y
);

  localparam logic [4:0] SETTLE_LAST = 5'(SETTLE_CYCLES);
  localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       x_q, x_d, y_q, y_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [1:0] ff_q, ff_d;
  logic       ffv_q, ffv_d;
  logic       ill_q, ill_d;

  logic gate_out, model_out, mismatch;

  gate_nand_unit u_gate (
    .s  (gate_out),
    .a  (x_q),
    .b  (y_q),
    .op (op_q)
  );

  assign model_out = (op_q == OP_NAND) ? ~(x_q & y_q) :
                     (op_q == OP_NOR)  ? ~(x_q | y_q) :
                     (op_q == OP_AND)  ?  (x_q & y_q) :
                     (op_q == OP_OR)   ?  (x_q | y_q) :
                     (op_q == OP_XOR)  ?  (x_q ^ y_q) :
                     (op_q == OP_XNOR) ? ~(x_q ^ y_q) : 1'b0;

  assign mismatch = gate_out ^ mask_q[vec_q] ^ model_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      mask_q  <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    ill_d   = ill_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op_is_legal(op)) begin
            op_d    = op;
            mask_d  = fault_mask;
            err_d   = '0;
            ff_d    = '0;
            ffv_d   = 1'b0;
            pass_d  = 1'b0;
            ill_d   = 1'b0;
            vec_d   = '0;
            state_d = ST_APPLY;
          end else begin
            ill_d   = 1'b1;
            pass_d  = 1'b0;
            err_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_APPLY: begin
        {x_d, y_d} = vec_q;
        cnt_d      = '0;
        state_d    = (SETTLE_CYCLES == 0) ? ST_COMPARE : ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (({1'b0, cnt_q} + 5'd1) >= SETTLE_LAST) begin
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (mismatch) begin
          err_d = err_q + 3'd1;
          if (!ffv_q) begin
            ff_d  = vec_q;
            ffv_d = 1'b1;
          end
        end
        // pass is resolved here so it reflects this compare's count on DONE entry
        if (vec_q == LAST_VEC) begin
          pass_d  = (err_d == 3'd0) && !ill_q;
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          state_d = ST_APPLY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;
  assign illegal_op       = ill_q;
  assign x                = x_q;
  assign y                = y_q;

endmodule

// File: tb/tb_gate_eval_sequencer.sv
// Bench for gate_eval_sequencer: a timeline model predicts every output from the edge count
// since the accepted start and the latched fault mask; directed sweeps add literal checks.
module tb_gate_eval_sequencer;

  localparam int P = 3;  // SETTLE_CYCLES + 2 cycles per vector

  logic       clk = 1'b0;
  logic       reset, start;
  logic [2:0] op;
  logic [3:0] fault_mask;
  logic       busy, done, pass, first_fail_valid, illegal_op, x, y;
  logic [2:0] err_count;
  logic [1:0] first_fail;

  int n_assert = 0;
  int n_fail   = 0;

  gate_eval_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .op               (op),
    .fault_mask       (fault_mask),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail       (first_fail),
    .first_fail_valid (first_fail_valid),
    .illegal_op       (illegal_op),
    .x                (x),
    .y                (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model
  logic       m_on = 1'b0;
  logic       m_active, m_ill;
  logic [3:0] m_mask;
  int         k;
  logic       e_busy, e_done, e_pass, e_ffv, e_ill;
  logic [2:0] e_err;
  logic [1:0] e_ff, e_xy;

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1'b1; m_active = 1'b0; m_ill = 1'b0; m_mask = '0; k = 0;
      e_busy = 0; e_done = 0; e_pass = 0; e_ffv = 0; e_ill = 0;
      e_err = '0; e_ff = '0; e_xy = '0;
    end else if (m_on) begin
      if (!m_active) begin
        e_busy = 1'b0;
        e_done = 1'b0;
        if (start) begin
          m_active = 1'b1;
          k = 0;
          m_ill = (op >= 3'd6);
          e_busy = 1'b1;
          e_ill = m_ill;
          e_pass = 1'b0;
          e_err = '0;
          if (m_ill) begin
            e_done = 1'b1;
          end else begin
            m_mask = fault_mask;
            e_ff = '0;
            e_ffv = 1'b0;
          end
        end
      end else begin
        k++;
        if (m_ill) begin
          m_active = 1'b0;
          e_busy = 1'b0;
          e_done = 1'b0;
        end else begin
          int nd;
          e_busy = (k <= 4 * P);
          e_done = (k == 4 * P);
          if (k <= 4 * P) begin
            e_xy = ((k - 1) / P > 3) ? 2'd3 : 2'((k - 1) / P);
            nd = (k / P > 4) ? 4 : k / P;
            e_err = '0; e_ff = '0; e_ffv = 1'b0;
            for (int v = 0; v < nd; v++) begin
              if (m_mask[v]) begin
                e_err++;
                if (!e_ffv) begin
                  e_ff = 2'(v);
                  e_ffv = 1'b1;
                end
              end
            end
          end
          if (k == 4 * P) e_pass = (e_err == 3'd0);
          if (k >= 4 * P + 1) m_active = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("cmp_busy", 32'(busy), 32'(e_busy));
      check("cmp_done", 32'(done), 32'(e_done));
      check("cmp_pass", 32'(pass), 32'(e_pass));
      check("cmp_err_count", 32'(err_count), 32'(e_err));
      check("cmp_first_fail", 32'(first_fail), 32'(e_ff));
      check("cmp_first_fail_valid", 32'(first_fail_valid), 32'(e_ffv));
      check("cmp_illegal_op", 32'(illegal_op), 32'(e_ill));
      check("cmp_xy", 32'({x, y}), 32'(e_xy));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_sweep(input logic [2:0] o, input logic [3:0] m);
    op = o;
    fault_mask = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; fault_mask = '0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err_count), 32'd0);
    check("reset_pass", 32'(pass), 32'd0);
    reset = 1'b0;
    tick();

    // Illegal op: single busy/done cycle
    op = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("ill_busy", 32'(busy), 32'd1);
    check("ill_done", 32'(done), 32'd1);
    check("ill_flag", 32'(illegal_op), 32'd1);
    check("ill_pass", 32'(pass), 32'd0);
    check("ill_err", 32'(err_count), 32'd0);
    check("ill_xy", 32'({x, y}), 32'd0);
    tick();
    check("ill_busy_after", 32'(busy), 32'd0);
    check("ill_done_after", 32'(done), 32'd0);

    // NAND sweep with exact edge timing
    op = 3'd0; fault_mask = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (e == 1)  check("nand_xy_e1", 32'({x, y}), 32'd0);
      if (e == 4)  check("nand_xy_e4", 32'({x, y}), 32'd1);
      if (e == 7)  check("nand_xy_e7", 32'({x, y}), 32'd2);
      if (e == 10) check("nand_xy_e10", 32'({x, y}), 32'd3);
      if (e == 11) check("nand_done_e11", 32'(done), 32'd0);
      if (e == 12) check("nand_done_e12", 32'(done), 32'd1);
      if (e == 13) check("nand_busy_e13", 32'(busy), 32'd0);
    end
    check("nand_pass", 32'(pass), 32'd1);
    check("nand_err", 32'(err_count), 32'd0);
    check("nand_ffv", 32'(first_fail_valid), 32'd0);
    check("nand_ill_cleared", 32'(illegal_op), 32'd0);

    // XOR with fault on vector 2
    run_sweep(3'd4, 4'b0100);
    check("xor_err", 32'(err_count), 32'd1);
    check("xor_ff", 32'(first_fail), 32'd2);
    check("xor_ffv", 32'(first_fail_valid), 32'd1);
    check("xor_pass", 32'(pass), 32'd0);

    // NOR, all vectors faulted, start held for back-to-back sweeps
    op = 3'd1; fault_mask = 4'b1111; start = 1'b1;
    tick();
    wait_done();
    check("nor1_err", 32'(err_count), 32'd4);
    check("nor1_ff", 32'(first_fail), 32'd0);
    check("nor1_pass", 32'(pass), 32'd0);
    tick();
    check("nor_idle_gap", 32'(busy), 32'd0);
    tick();
    check("nor2_restart", 32'(busy), 32'd1);
    check("nor2_err_cleared", 32'(err_count), 32'd0);
    wait_done();
    start = 1'b0;
    check("nor2_err", 32'(err_count), 32'd4);
    check("nor2_ff", 32'(first_fail), 32'd0);
    check("nor2_ffv", 32'(first_fail_valid), 32'd1);
    check("nor2_pass", 32'(pass), 32'd0);
    tick();
    tick();
    check("nor2_stopped", 32'(busy), 32'd0);

    // Reset during SETTLE of vector 1
    op = 3'd2; fault_mask = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_xy", 32'({x, y}), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("rst_no_done", 32'(done), 32'd0);
    end
    run_sweep(3'd2, 4'b0000);
    check("and_after_rst_pass", 32'(pass), 32'd1);

    // Inputs changed mid-sweep are ignored
    op = 3'd2; fault_mask = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    op = 3'd3;
    fault_mask = 4'b1111;
    wait_idle();
    check("midchange_pass", 32'(pass), 32'd1);
    check("midchange_err", 32'(err_count), 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_eval_sequencer.md
# gate_eval_sequencer

Self-checking sequencer for the two-input gate library. It sweeps all four input vectors through a NAND-only gate-level unit and a behavioural expression model of the same function, and compares the two outputs on every vector. It reports the mismatch count, the first failing vector and a pass flag over a start/busy/done handshake. It sits beside the gate modules as the on-chip replacement for hand-written `$monitor` benches.

## Interface
Parameters:
- SETTLE_CYCLES, 1, wait cycles between applying a vector and comparing; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- op  input  3  function select: 0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR; 6 and 7 are illegal.
- fault_mask  input  4  bit v set inverts the gate-level output for vector v (test hook); 0 in normal use.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse, high exactly while state = DONE.
- pass  output  1  result of the last completed sweep; held until the next accepted start.
- err_count  output  3  number of mismatching vectors, 0..4.
- first_fail  output  2  vector {x,y} of the first mismatch.
- first_fail_valid  output  1  first_fail holds a real mismatch.
- illegal_op  output  1  last accepted op was 6 or 7.
- x, y  output  1 each  vector currently driven into both units (registered).

## Operation
- FSM states: IDLE, APPLY, SETTLE, COMPARE, DONE.
- IDLE, start = 1, legal op:
  - latch op and fault_mask;
  - clear err_count, first_fail, first_fail_valid, pass and illegal_op;
  - set vec = 0 and go to APPLY.
- IDLE, start = 1, op ≥ 6: set illegal_op = 1, pass = 0, err_count = 0, then go directly to DONE.
- APPLY: {x,y} ← vec and settle counter ← 0. Go to SETTLE, or to COMPARE when SETTLE_CYCLES = 0.
- SETTLE: increment the counter; go to COMPARE once SETTLE_CYCLES cycles have been spent in SETTLE.
- COMPARE: mismatch = gate_out ^ fault_mask[vec] ^ model_out. On a mismatch:
  - increment err_count;
  - if first_fail_valid = 0, capture first_fail = vec and set first_fail_valid = 1.
- COMPARE exit: if vec = 3, go to DONE; otherwise vec ← vec + 1 and go to APPLY. vec never wraps within a sweep.
- DONE: on entry, pass ← (err_count_next == 0) && !illegal_op. Return to IDLE unconditionally.
- start is ignored in every state except IDLE, including DONE. Changes to op and fault_mask during a sweep have no effect.
- reset: all outputs and internal registers return to 0 on the next edge, from any state; state ← IDLE. Any sweep in progress is abandoned with no done pulse.

## Timing
- Reset value of every output is 0.
- Number edges with the edge that samples start as edge 0.
- APPLY for vector v is entered at edge 1 + v·(SETTLE_CYCLES + 2) − 1. Each vector occupies SETTLE_CYCLES + 2 cycles.
- Legal op: DONE is entered at edge 4·(SETTLE_CYCLES + 2); with SETTLE_CYCLES = 1 that is edge 12. done is high for the following cycle. IDLE is re-entered one edge later.
- Illegal op: DONE is entered at edge 0, and busy and done are high for one cycle.
- Back-to-back sweeps: with start held high, the next start is sampled on the first edge in IDLE, i.e. the edge after DONE.
- err_count, first_fail and pass update registered, at the COMPARE or DONE exit edge.

## Structure
- Package gate_eval_pkg holds:
  - op code constants OP_NAND..OP_XNOR and OP_LAST_LEGAL = 5;
  - state encoding constants;
  - NUM_VECTORS = 4.
- Sub-module gate_nand_unit(s, a, b, op): builds all six functions from 2-input nand primitives only, muxed by op.
- The expression model is an inline continuous assign in the top level.

## Test plan
- op = 0, fault_mask = 0, SETTLE_CYCLES = 1, pulse start → x,y sweep 00, 01, 10, 11; done high in the cycle after edge 12; pass = 1, err_count = 0, first_fail_valid = 0.
- op = 4, fault_mask = 4'b0100 → err_count = 1, first_fail = 2'b10, first_fail_valid = 1, pass = 0.
- op = 7, pulse start → busy and done high for the single cycle after edge 0; illegal_op = 1, pass = 0, err_count = 0, x = y = 0.
- op = 1, fault_mask = 4'b1111, start held high → err_count = 4, first_fail = 2'b00. A second sweep begins on the edge after DONE and gives identical results.
- Assert reset during SETTLE of vector 1 → after the next edge, busy = 0, x = y = 0, err_count = 0, and no done pulse. A following start with op = 2 completes with pass = 1.
- op = 2 at start, switched to 3 at edge 5 → the sweep still evaluates AND; pass = 1 with fault_mask = 0.
